// File: rtl/async_fifo_gray.sv
// async_fifo_gray: dual-clock FIFO carrying DW-bit words from clkw to clkr.
// Pointers cross domains only in Gray form, through SYNC_STAGES-flop
// synchronisers. Flags and counts are registered and pessimistic.
// Ports:
//   clkw, rst (async active-low, clears both domains), clkr
//   write side (clkw): wreq, wd -> full, afull, wcount, overflow
//   read side  (clkr): rreq     -> rd, rvalid, empty, aempty, rcount, underflow
module async_fifo_gray #(
  parameter int DW          = 8,
  parameter int AW          = 4,
  parameter int AFULL_TH    = (1 << AW) - 2,
  parameter int AEMPTY_TH   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clkw,
  input  logic          rst,
  input  logic          clkr,
  input  logic          wreq,
  input  logic [DW-1:0] wd,
  output logic          full,
  output logic          afull,
  output logic [AW:0]   wcount,
  output logic          overflow,
  input  logic          rreq,
  output logic [DW-1:0] rd,
  output logic          rvalid,
  output logic          empty,
  output logic          aempty,
  output logic [AW:0]   rcount,
  output logic          underflow
);

  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] AFULL_V  = PW'(AFULL_TH);
  localparam logic [AW:0] AEMPTY_V = PW'(AEMPTY_TH);

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [DW-1:0] mem_r [0:DEPTH-1];

  // ---------------- write domain ----------------
  logic [1:0]    wrst_r;
  logic [AW:0]   wbin_r, wgray_r;
  logic [AW:0]   rgray_sync_r [0:SYNC_STAGES-1];
  logic          full_r, afull_r, overflow_r;
  logic [AW:0]   wcount_r;
  logic          winc_s, full_next_s;
  logic [AW:0]   wbin_next_s, wgray_next_s, wcount_next_s, rgray_sync_s;

  // Reset release synchroniser for the write domain; writes are held off until it settles.
  always_ff @(posedge clkw or negedge rst) begin
    if (!rst) wrst_r <= 2'b00;
    else      wrst_r <= {wrst_r[0], 1'b1};
  end

  assign rgray_sync_s = rgray_sync_r[SYNC_STAGES-1];

  // Write-side next-state: pointer advance, full test against the synchronised read pointer.
  always_comb begin
    winc_s        = wreq & ~full_r & wrst_r[1];
    wbin_next_s   = wbin_r + {{AW{1'b0}}, winc_s};
    wgray_next_s  = bin2gray(wbin_next_s);
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    full_next_s   = (wgray_next_s == {~rgray_sync_s[AW:AW-1], rgray_sync_s[AW-2:0]});
    wcount_next_s = wbin_next_s - gray2bin(rgray_sync_s);
  end

  // Storage array; written only on accepted writes and never reset.
  always_ff @(posedge clkw) begin
    if (winc_s) mem_r[wbin_r[AW-1:0]] <= wd;
  end

  // Write-domain state, flags and read-pointer synchroniser.
  always_ff @(posedge clkw or negedge rst) begin
    if (!rst) begin
      wbin_r     <= {PW{1'b0}};
      wgray_r    <= {PW{1'b0}};
      full_r     <= 1'b0;
      afull_r    <= 1'b0;
      wcount_r   <= {PW{1'b0}};
      overflow_r <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) rgray_sync_r[i] <= {PW{1'b0}};
    end else begin
      wbin_r     <= wbin_next_s;
      wgray_r    <= wgray_next_s;
      full_r     <= full_next_s;
      afull_r    <= (wcount_next_s >= AFULL_V);
      wcount_r   <= wcount_next_s;
      overflow_r <= wreq & full_r;
      rgray_sync_r[0] <= rgray_r;
      for (int i = 1; i < SYNC_STAGES; i++) rgray_sync_r[i] <= rgray_sync_r[i-1];
    end
  end

  // ---------------- read domain ----------------
  logic [1:0]    rrst_r;
  logic [AW:0]   rbin_r, rgray_r;
  logic [AW:0]   wgray_sync_r [0:SYNC_STAGES-1];
  logic          empty_r, aempty_r, underflow_r, rvalid_r;
  logic [AW:0]   rcount_r;
  logic [DW-1:0] rd_r;
  logic          rinc_s;
  logic [AW:0]   rbin_next_s, rgray_next_s, rcount_next_s, wgray_sync_s;

  // Reset release synchroniser for the read domain; reads are held off until it settles.
  always_ff @(posedge clkr or negedge rst) begin
    if (!rst) rrst_r <= 2'b00;
    else      rrst_r <= {rrst_r[0], 1'b1};
  end

  assign wgray_sync_s = wgray_sync_r[SYNC_STAGES-1];

  // Read-side next-state: pointer advance and occupancy against the synchronised write pointer.
  always_comb begin
    rinc_s        = rreq & ~empty_r & rrst_r[1];
    rbin_next_s   = rbin_r + {{AW{1'b0}}, rinc_s};
    rgray_next_s  = bin2gray(rbin_next_s);
    rcount_next_s = gray2bin(wgray_sync_s) - rbin_next_s;
  end

  // Read-domain state, registered read data, flags and write-pointer synchroniser.
  always_ff @(posedge clkr or negedge rst) begin
    if (!rst) begin
      rbin_r      <= {PW{1'b0}};
      rgray_r     <= {PW{1'b0}};
      empty_r     <= 1'b1;
      aempty_r    <= 1'b1;
      rcount_r    <= {PW{1'b0}};
      underflow_r <= 1'b0;
      rvalid_r    <= 1'b0;
      rd_r        <= {DW{1'b0}};
      for (int i = 0; i < SYNC_STAGES; i++) wgray_sync_r[i] <= {PW{1'b0}};
    end else begin
      rbin_r      <= rbin_next_s;
      rgray_r     <= rgray_next_s;
      empty_r     <= (rgray_next_s == wgray_sync_s);
      aempty_r    <= (rcount_next_s <= AEMPTY_V);
      rcount_r    <= rcount_next_s;
      underflow_r <= rreq & empty_r;
      rvalid_r    <= rinc_s;
      if (rinc_s) rd_r <= mem_r[rbin_r[AW-1:0]];
      else        rd_r <= rd_r;
      wgray_sync_r[0] <= wgray_r;
      for (int i = 1; i < SYNC_STAGES; i++) wgray_sync_r[i] <= wgray_sync_r[i-1];
    end
  end

  assign full      = full_r;
  assign afull     = afull_r;
  assign wcount    = wcount_r;
  assign overflow  = overflow_r;
  assign rd        = rd_r;
  assign rvalid    = rvalid_r;
  assign empty     = empty_r;
  assign aempty    = aempty_r;
  assign rcount    = rcount_r;
  assign underflow = underflow_r;

endmodule
